// File: rtl/gauss_jordan_sequencer.sv
// Gauss-Jordan control sequencer: walks the augmented matrix [A | I] and
// issues LOADP / NORM / LOADF / ELIM operations one at a time over a
// valid/ready handshake. A zero pivot aborts the sequence with a sticky
// singular flag. No row swapping is attempted.
module gauss_jordan_sequencer #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             singular,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [1:0]       op_code,
  output logic [IDX_W-1:0] op_k,
  output logic [IDX_W-1:0] op_i,
  output logic [IDX_W:0]   op_j,
  input  logic             pivot_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PIVOT,
    S_NORM,
    S_FACT,
    S_ELIM,
    S_FIN
  } state_t;

  localparam logic [1:0] OP_LOADP = 2'd0;
  localparam logic [1:0] OP_NORM  = 2'd1;
  localparam logic [1:0] OP_LOADF = 2'd2;
  localparam logic [1:0] OP_ELIM  = 2'd3;

  localparam logic [IDX_W:0]   J_LAST = (IDX_W+1)'(2*N-1);
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N-1);
  localparam logic [IDX_W:0]   N_ROWS = (IDX_W+1)'(N);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] k, k_nxt;
  logic [IDX_W-1:0] i, i_nxt;
  logic [IDX_W:0]   j, j_nxt;
  logic             singular_nxt;

  logic [IDX_W:0]   first_row;
  logic [IDX_W:0]   next_row;
  logic             first_found;
  logic             next_found;

  // Smallest row index >= from that is not the pivot row. The result is one
  // bit wider than a row index so running off the end (== N) is detectable.
  function automatic logic [IDX_W:0] row_skip_pivot(input logic [IDX_W:0]   from,
                                                    input logic [IDX_W-1:0] piv);
    logic [IDX_W:0] cand;
    cand = from;
    if (cand == {1'b0, piv}) cand = cand + (IDX_W+1)'(1);
    return cand;
  endfunction

  // Candidate target rows for the first and the following elimination passes.
  always_comb begin
    first_row   = row_skip_pivot('0, k);
    next_row    = row_skip_pivot({1'b0, i} + (IDX_W+1)'(1), k);
    first_found = (first_row < N_ROWS);
    next_found  = (next_row < N_ROWS);
  end

  // State and index registers; everything here is control, so all of it resets.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      k        <= '0;
      i        <= '0;
      j        <= '0;
      singular <= 1'b0;
    end else begin
      state    <= state_nxt;
      k        <= k_nxt;
      i        <= i_nxt;
      j        <= j_nxt;
      singular <= singular_nxt;
    end
  end

  // Next-state and index update; the sequence only moves on an accepted op.
  always_comb begin
    state_nxt    = state;
    k_nxt        = k;
    i_nxt        = i;
    j_nxt        = j;
    singular_nxt = singular;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          singular_nxt = 1'b0;
          k_nxt        = '0;
          i_nxt        = '0;
          j_nxt        = '0;
          state_nxt    = S_PIVOT;
        end
      end
      S_PIVOT: begin
        if (op_ready) begin
          if (pivot_zero) begin
            singular_nxt = 1'b1;
            state_nxt    = S_FIN;
          end else begin
            j_nxt     = '0;
            state_nxt = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (op_ready) begin
          if (j == J_LAST) begin
            if (first_found) begin
              i_nxt     = first_row[IDX_W-1:0];
              state_nxt = S_FACT;
            end else if (k == K_LAST) begin
              state_nxt = S_FIN;
            end else begin
              k_nxt     = k + IDX_W'(1);
              state_nxt = S_PIVOT;
            end
          end else begin
            j_nxt = j + (IDX_W+1)'(1);
          end
        end
      end
      S_FACT: begin
        if (op_ready) begin
          j_nxt     = '0;
          state_nxt = S_ELIM;
        end
      end
      S_ELIM: begin
        if (op_ready) begin
          if (j != J_LAST) begin
            j_nxt = j + (IDX_W+1)'(1);
          end else if (next_found) begin
            i_nxt     = next_row[IDX_W-1:0];
            state_nxt = S_FACT;
          end else if (k == K_LAST) begin
            state_nxt = S_FIN;
          end else begin
            k_nxt     = k + IDX_W'(1);
            state_nxt = S_PIVOT;
          end
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operation fields come straight from registers, so they stay stable while
  // the datapath stalls. LOADP/NORM address the pivot row; LOADP/LOADF read
  // the pivot column.
  always_comb begin
    op_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    op_code  = OP_LOADP;
    op_k     = k;
    op_i     = i;
    op_j     = j;
    unique case (state)
      S_PIVOT: begin
        op_valid = 1'b1;
        busy     = 1'b1;
        op_code  = OP_LOADP;
        op_i     = k;
        op_j     = {1'b0, k};
      end
      S_NORM: begin
        op_valid = 1'b1;
        busy     = 1'b1;
        op_code  = OP_NORM;
        op_i     = k;
      end
      S_FACT: begin
        op_valid = 1'b1;
        busy     = 1'b1;
        op_code  = OP_LOADF;
        op_j     = {1'b0, k};
      end
      S_ELIM: begin
        op_valid = 1'b1;
        busy     = 1'b1;
        op_code  = OP_ELIM;
      end
      S_FIN: begin
        done = 1'b1;
      end
      default: begin
        op_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_gauss_jordan_sequencer.sv
// Directed bench for gauss_jordan_sequencer: an N=3 instance for the full
// sequence, backpressure, singular abort and reset/robustness cases, and an
// N=1 instance for the degenerate sequence.
module tb_gauss_jordan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       op_ready = 1'b1;
  logic       pivot_zero = 1'b0;
  logic       busy, done, singular, op_valid;
  logic [1:0] op_code;
  logic [1:0] op_k, op_i;
  logic [2:0] op_j;

  logic       start1 = 1'b0;
  logic       op_ready1 = 1'b1;
  logic       pivot_zero1 = 1'b0;
  logic       busy1, done1, singular1, op_valid1;
  logic [1:0] op_code1;
  logic [0:0] op_k1, op_i1;
  logic [1:0] op_j1;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] exp_ops[$];

  gauss_jordan_sequencer #(.N(3), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .singular(singular), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_k(op_k), .op_i(op_i), .op_j(op_j),
    .pivot_zero(pivot_zero)
  );

  gauss_jordan_sequencer #(.N(1), .IDX_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .singular(singular1), .op_valid(op_valid1), .op_ready(op_ready1),
    .op_code(op_code1), .op_k(op_k1), .op_i(op_i1), .op_j(op_j1),
    .pivot_zero(pivot_zero1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [8:0] pk(input int c, input int kk, input int ii, input int jj);
    return {2'(c), 2'(kk), 2'(ii), 3'(jj)};
  endfunction

  // Expected N=3 op stream: per pivot, LOADP, NORM over all 6 columns, then
  // for each other row LOADF followed by ELIM over all 6 columns.
  task automatic build_expected();
    exp_ops.delete();
    for (int kk = 0; kk < 3; kk++) begin
      exp_ops.push_back(pk(0, kk, kk, kk));
      for (int jj = 0; jj < 6; jj++) exp_ops.push_back(pk(1, kk, kk, jj));
      for (int ii = 0; ii < 3; ii++) begin
        if (ii != kk) begin
          exp_ops.push_back(pk(2, kk, ii, kk));
          for (int jj = 0; jj < 6; jj++) exp_ops.push_back(pk(3, kk, ii, jj));
        end
      end
    end
  endtask

  // One N=3 run from a start pulse. stall_at/stall_len hold op_ready low while
  // that op is presented; zero_at raises pivot_zero on that op's handshake;
  // mid_start pulses start at that cycle; rst_cyc asserts rst at that cycle.
  task automatic run_seq(input int stall_at, input int stall_len, input int zero_at,
                         input int mid_start, input int rst_cyc,
                         input int exp_done_cyc, input logic exp_sing);
    int  idx;
    int  stalls;
    int  cyc;
    bit  fin;
    bit  aborted;
    logic [8:0] cur;
    idx = 0; stalls = 0; fin = 0; aborted = 0;
    @(posedge clk); #1;
    start = 1'b1; op_ready = 1'b1; pivot_zero = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("singular_clear_on_start", 32'(singular), 32'(0));
    for (cyc = 1; cyc < 200 && !fin; cyc++) begin
      start = (cyc == mid_start);
      if (cyc == rst_cyc) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("rst_mid_outputs",
            32'({busy, done, singular, op_valid, op_code, op_k, op_i, op_j}), 32'(0));
        repeat (3) begin
          @(posedge clk); #1;
          chk("post_rst_idle", 32'({busy, done, op_valid}), 32'(0));
        end
        return;
      end
      if (idx < exp_ops.size() && !aborted) begin
        cur = {op_code, op_k, op_i, op_j};
        chk("op_valid", 32'(op_valid), 32'(1));
        chk("busy", 32'(busy), 32'(1));
        chk($sformatf("op%0d_cyc%0d", idx + 1, cyc), 32'(cur), 32'(exp_ops[idx]));
        op_ready = !(idx == stall_at && stalls < stall_len);
        if (!op_ready) stalls++;
        if (idx == zero_at) pivot_zero = 1'b1;
        else if (exp_ops[idx][8:7] != 2'd0) pivot_zero = 1'($urandom_range(0, 1));
        else pivot_zero = 1'b0;
        if (op_ready) begin
          if (idx == zero_at) aborted = 1;
          idx++;
        end
      end else begin
        op_ready = 1'b1; pivot_zero = 1'b0;
        chk("done_cycle", 32'(cyc), 32'(exp_done_cyc));
        chk("done", 32'(done), 32'(1));
        chk("busy_at_done", 32'(busy), 32'(0));
        chk("op_valid_at_done", 32'(op_valid), 32'(0));
        chk("singular_at_done", 32'(singular), 32'(exp_sing));
        fin = 1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (!fin) chk("timeout_waiting_done", 32'(0), 32'(1));
    chk("done_one_cycle", 32'(done), 32'(0));
    chk("op_valid_after_done", 32'(op_valid), 32'(0));
  endtask

  initial begin
    build_expected();

    // Reset held two cycles with random start/op_ready.
    rst = 1'b1;
    repeat (2) begin
      start = 1'($urandom_range(0, 1));
      op_ready = 1'($urandom_range(0, 1));
      start1 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("reset_outputs",
          32'({busy, done, singular, op_valid, op_code, op_k, op_i, op_j}), 32'(0));
      chk("reset_outputs_n1",
          32'({busy1, done1, singular1, op_valid1, op_code1, op_k1, op_i1, op_j1}), 32'(0));
    end
    rst = 1'b0; start = 1'b0; start1 = 1'b0; op_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_no_op_valid", 32'({op_valid, busy, done}), 32'(0));
    end

    // Spot checks of the expected stream against hand-derived op positions.
    chk("exp_op1", 32'(exp_ops[0]), 32'(9'b00_00_00_000));
    chk("exp_op22", 32'(exp_ops[21]), 32'(9'b00_01_01_001));
    chk("exp_op63", 32'(exp_ops[62]), 32'(9'b11_10_01_101));
    chk("exp_count", 32'(exp_ops.size()), 32'(63));

    // Full N=3 run.
    run_seq(-1, 0, -1, -1, -1, 64, 1'b0);

    // Backpressure on (ELIM,0,2,3), the 19th op.
    run_seq(18, 3, -1, -1, -1, 67, 1'b0);

    // Singular abort at the op-22 LOADP.
    run_seq(-1, 0, 21, -1, -1, 23, 1'b1);
    repeat (9) begin
      @(posedge clk); #1;
      chk("no_op_after_singular", 32'({op_valid, busy, done}), 32'(0));
    end
    chk("singular_sticky", 32'(singular), 32'(1));

    // Fresh start clears singular; mid-run start pulse is ignored.
    run_seq(-1, 0, -1, 10, -1, 64, 1'b0);

    // rst at cycle 30, then a fresh start restarts from (LOADP,0,0,0).
    run_seq(-1, 0, -1, -1, 30, 0, 1'b0);
    run_seq(-1, 0, -1, -1, -1, 64, 1'b0);

    // N=1 degenerate sequence.
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("n1_op1", 32'({op_valid1, op_code1, op_k1, op_i1, op_j1}), 32'(7'b1_00_0_0_00));
    @(posedge clk); #1;
    chk("n1_op2", 32'({op_valid1, op_code1, op_k1, op_i1, op_j1}), 32'(7'b1_01_0_0_00));
    @(posedge clk); #1;
    chk("n1_op3", 32'({op_valid1, op_code1, op_k1, op_i1, op_j1}), 32'(7'b1_01_0_0_01));
    @(posedge clk); #1;
    chk("n1_done", 32'({done1, busy1, op_valid1, singular1}), 32'(4'b1000));
    @(posedge clk); #1;
    chk("n1_idle", 32'({done1, busy1, op_valid1}), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gauss_jordan_sequencer.md
# gauss_jordan_sequencer

Control sequencer for the matrix-inversion datapath. It walks an N×N Gauss-Jordan elimination over the augmented matrix [A | I] (N rows, 2N columns), issuing one operation at a time to the shared arithmetic datapath through a valid/ready handshake. It tracks pivot, row and column indices, aborts with a singular flag when a pivot is zero, and signals completion to the top level. No row swapping: a zero pivot is terminal.

## Interface
- N, default 3: matrix dimension, ≥1
- IDX_W, default 2: row/pivot index width, N ≤ 2^IDX_W
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin inversion; accepted only in IDLE
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse (normal or singular)
- singular  out  1  sticky; set on zero pivot, cleared on accepted start or rst
- op_valid  out  1  operation presented
- op_ready  in  1  datapath accepts operation
- op_code  out  2  0 LOADP (latch pivot a[k][k]), 1 NORM (a[k][j] /= pivot), 2 LOADF (latch factor a[i][k]), 3 ELIM (a[i][j] -= factor·a[k][j])
- op_k  out  IDX_W  current pivot index
- op_i  out  IDX_W  target row
- op_j  out  IDX_W+1  target column, 0..2N-1
- pivot_zero  in  1  datapath flag: pivot is zero; sampled only on LOADP handshake

## Operation
- States: IDLE, PIVOT, NORM, FACT, ELIM, FIN.
- IDLE: op_valid=0, busy=0. On start=1, clear singular, set k=0, go to PIVOT.
- PIVOT: issue LOADP (k, i=k, j=k). On handshake: if pivot_zero=1, set singular, go to FIN; else j=0, go to NORM.
- NORM: issue NORM (k, i=k, j). On handshake: j==2N-1 → select first row i≠k; if none (N=1), go to the next-pivot step; else go to FACT. Otherwise j++.
- FACT: issue LOADF (k, i, j=k). On handshake: j=0, go to ELIM.
- ELIM: issue ELIM (k, i, j). On handshake: if j<2N-1, j++. Otherwise advance i to the next row ≠k. If a row remains, go to FACT; otherwise take the next-pivot step.
- Next-pivot step: if k==N-1, go to FIN; else k++, go to PIVOT.
- FIN: done=1 for exactly one cycle, busy=0. Return to IDLE. start is ignored in FIN.
- An operation advances only on op_valid&&op_ready. While op_valid=1 and op_ready=0, op_code/op_k/op_i/op_j are held stable.
- Ops per pivot: 1 + 2N + (N-1)(1+2N). Total for N=3: 63. For N=1: 3.
- start while busy: ignored. pivot_zero outside a LOADP handshake: ignored.

## Timing
- Reset values: busy=0, done=0, singular=0, op_valid=0, op_code=0, op_k=0, op_i=0, op_j=0; state IDLE.
- rst mid-sequence: next edge returns to IDLE with the values above. No done pulse.
- start sampled at edge T → op_valid=1 and busy=1 from cycle T+1.
- One op per cycle while op_ready=1. Handshake at edge T+m → next op presented at T+m+1.
- Final handshake at edge E → done=1, busy=0 in cycle E+1. IDLE in E+2, when a new start may be accepted.
- Singular abort: a LOADP handshake with pivot_zero=1 at edge E → done=1 and singular=1 in E+1. No further op_valid. singular holds until the next accepted start or rst.
- op_valid falls in the cycle done rises.

## Test plan
- Reset: hold rst 2 cycles with random op_ready/start → every output 0. After release with start=0, op_valid stays 0.
- N=3, op_ready=1, pivot_zero=0, start pulse at cycle 0 → ops in cycles 1..63 exactly as follows:
  - first four: (LOADP,0,0,0), (NORM,0,0,0..5), (LOADF,0,1,0), (ELIM,0,1,0..5)
  - op 22 is (LOADP,1,1,1)
  - last op is (ELIM,2,1,5)
  - done=1 and busy=0 in cycle 64; singular=0.
- Backpressure: as above, but op_ready=0 for 3 cycles during (ELIM,0,2,3) → fields held stable, no duplicate or skipped op, done in cycle 67.
- Singular: as above, with pivot_zero=1 at the op-22 handshake (LOADP k=1) → no op_valid after cycle 22, done=singular=1 in cycle 23. singular is still 1 ten cycles later and clears on the next start.
- Robustness: a start pulse at cycle 10 mid-run is ignored (sequence unchanged). rst at cycle 30 → IDLE next cycle, no done. A fresh start then restarts from (LOADP,0,0,0).
- N=1, IDX_W=1 → ops (LOADP,0,0,0), (NORM,0,0,0), (NORM,0,0,1), then done in cycle 4.
